// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC-source encodings, the bubble instruction,
// the fetch FSM states and the pipeline-register update codes.
package pipe_pkg;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_J   = 2'b01;
  localparam logic [1:0] PC_SRC_JR  = 2'b10;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  // Same encoding as the decode-side pipeline-register control.
  typedef enum logic [1:0] {
    UPDATE = 2'b00,
    FLUSH  = 2'b01,
    HOLD   = 2'b10
  } preg_op_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus_4;
    logic        valid;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [31:0] nop, input logic [31:0] pc_plus_4);
    return '{inst: nop, pc_plus_4: pc_plus_4, valid: 1'b0};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port: the fetch stage is the master, the memory the slave.
// The memory returns imem_rdata in the same cycle it raises imem_ready.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_pc_sel.sv
// Combinational next-PC and IF/ID operation select. Priority, highest first:
// EX branch, stall, ID jump, memory ready, memory not ready.
module if_pc_sel
  import pipe_pkg::*;
(
  input  logic        active,
  input  logic [31:0] pc,
  input  logic [1:0]  id_pc_src,
  input  logic [31:0] jump_addr,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus_4,
  output preg_op_t    if_id_op,
  output logic        redirect
);

  assign pc_plus_4 = pc + 32'd4;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    pc_next  = pc;
    if_id_op = FLUSH;
    redirect = 1'b0;
    if (!active) begin
      // Boot cycle: no fetch outstanding, PC holds and IF/ID takes a bubble.
      if_id_op = FLUSH;
    end else if (ex_branch_taken) begin
      pc_next  = ex_branch_target;
      redirect = 1'b1;
    end else if (stall) begin
      // The jump operand may be stale under a load-use stall, so it waits too.
      if_id_op = HOLD;
    end else if (id_pc_src != PC_SRC_SEQ) begin
      pc_next  = jump_addr;
      redirect = 1'b1;
    end else if (imem_ready) begin
      pc_next  = pc_plus_4;
      if_id_op = UPDATE;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM and the IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/bubble performance counters.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        id_pc_src,
  input  logic [31:0]       jump_addr,
  input  logic              ex_branch_taken,
  input  logic [31:0]       ex_branch_target,
  input  logic              stall,
  if_stage_if.master        imem,
  output logic [31:0]       if_id_inst_out,
  output logic [31:0]       if_id_pc_plus_4_out,
  output logic              if_id_valid_out,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus_4;
  logic         req;
  logic         redirect;
  preg_op_t     if_id_op;
  if_id_t       if_id;

  if_pc_sel u_pc_sel (
    .active           (state != S_BOOT),
    .pc               (pc),
    .id_pc_src        (id_pc_src),
    .jump_addr        (jump_addr),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .stall            (stall),
    .imem_ready       (imem.imem_ready),
    .pc_next          (pc_next),
    .pc_plus_4        (pc_plus_4),
    .if_id_op         (if_id_op),
    .redirect         (redirect)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every flop sees pre-edge values.
    if (reset) begin
      state <= S_BOOT;
      req   <= 1'b0;
      pc    <= RESET_PC;
      if_id <= make_bubble(NOP_INST, 32'd0);
    end else begin
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (!imem.imem_ready && !redirect) state <= S_WAIT;
        S_WAIT:  if (imem.imem_ready || redirect) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
      // Every state reachable from here issues a request.
      req <= 1'b1;
      pc  <= pc_next;
      case (if_id_op)
        UPDATE:  if_id <= '{inst: imem.imem_rdata, pc_plus_4: pc_plus_4, valid: 1'b1};
        FLUSH:   if_id <= make_bubble(NOP_INST, pc_plus_4);
        default: if_id <= if_id;
      endcase
    end
  end

  assign imem.imem_addr      = pc;
  assign imem.imem_req       = req;
  assign if_id_inst_out      = if_id.inst;
  assign if_id_pc_plus_4_out = if_id.pc_plus_4;
  assign if_id_valid_out     = if_id.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  // Stall-hold cycles count as neither fetch nor bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (if_id_op == UPDATE) fetch_cnt  <= fetch_cnt + 32'd1;
      if (if_id_op == FLUSH)  bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage with a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  id_pc_src;
  logic [31:0] jump_addr;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        stall;
  logic [31:0] if_id_inst_out;
  logic [31:0] if_id_pc_plus_4_out;
  logic        if_id_valid_out;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  if_stage_if imem ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk                 (clk),
    .reset               (reset),
    .id_pc_src           (id_pc_src),
    .jump_addr           (jump_addr),
    .ex_branch_taken     (ex_branch_taken),
    .ex_branch_target    (ex_branch_target),
    .stall               (stall),
    .imem                (imem),
    .if_id_inst_out      (if_id_inst_out),
    .if_id_pc_plus_4_out (if_id_pc_plus_4_out),
    .if_id_valid_out     (if_id_valid_out),
    .perf_fetch_cnt      (perf_fetch_cnt),
    .perf_bubble_cnt     (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0001;
      32'h0000_0004: return 32'h2009_0002;
      32'h0000_002C: return 32'h8C08_0000;
      default:       return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
    endcase
  endfunction

  assign imem.imem_rdata = mem_word(imem.imem_addr);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] addr;
    logic        req;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state.
  logic [31:0] m_pc, m_inst, m_pc4, m_fcnt, m_bcnt;
  logic        m_valid;
  bit          m_boot;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_bubble();
    m_inst  = NOP;
    m_pc4   = m_pc + 32'd4;
    m_valid = 1'b0;
    m_bcnt  = m_bcnt + 32'd1;
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected post-edge state.
  task automatic step(input bit rst, input logic [1:0] src, input logic [31:0] ja,
                      input bit br, input logic [31:0] bt, input bit st, input bit rdy);
    exp_t e;
    reset            = rst;
    id_pc_src        = src;
    jump_addr        = ja;
    ex_branch_taken  = br;
    ex_branch_target = bt;
    stall            = st;
    imem.imem_ready  = rdy;
    if (rst) begin
      m_pc = RESET_PC; m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
      m_boot = 1'b1; m_fcnt = 32'd0; m_bcnt = 32'd0;
    end else if (m_boot) begin
      m_bubble();
      m_boot = 1'b0;
    end else if (br) begin
      m_bubble();
      m_pc = bt;
    end else if (st) begin
      // everything holds
    end else if (src != 2'b00) begin
      m_bubble();
      m_pc = ja;
    end else if (rdy) begin
      m_inst  = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_fcnt  = m_fcnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_bubble();
    end
    e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.addr = m_pc;
    e.req = !m_boot; e.fcnt = m_fcnt; e.bcnt = m_bcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input bit rdy);
    step(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic jump(input logic [31:0] target);
    step(1'b0, 2'b01, target, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  // Monitor: compares the DUT against the queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("if_id_inst", if_id_inst_out, e.inst);
        check("if_id_pc_plus_4", if_id_pc_plus_4_out, e.pc4);
        check("if_id_valid", {31'd0, if_id_valid_out}, {31'd0, e.valid});
        check("imem_addr", imem.imem_addr, e.addr);
        check("imem_req", {31'd0, imem.imem_req}, {31'd0, e.req});
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, e.fcnt);
        check("perf_bubble_cnt", perf_bubble_cnt, e.bcnt);
`else
        check("perf_fetch_cnt_tied", perf_fetch_cnt, 32'h0);
        check("perf_bubble_cnt_tied", perf_bubble_cnt, 32'h0);
`endif
      end
    end
  end

  initial begin
    m_pc = RESET_PC; m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    m_boot = 1'b1; m_fcnt = 32'd0; m_bcnt = 32'd0;

    step(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    seq(1'b1);                                  // boot cycle
    repeat (4) seq(1'b1);                       // 0x0..0xC, zero-wait
    repeat (3) seq(1'b0);                       // PC=0x10 waits three cycles
    repeat (5) seq(1'b1);                       // 0x10..0x20
    jump(32'h0000_0100);                        // jump at PC=0x24
    seq(1'b1);                                  // fetch 0x100
    jump(32'h0000_002C);
    seq(1'b1);                                  // IF/ID = {0x8C080000, 0x30}
    step(1'b0, 2'b01, 32'h0000_0400, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) seq(1'b1);                       // resumes at 0x30
    step(1'b0, 2'b01, 32'h0000_0300, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    seq(1'b1);                                  // fetch 0x200
    jump(32'hFFFF_FFFC);
    seq(1'b1);                                  // pc_plus_4 wraps to 0
    repeat (2) seq(1'b0);                       // waiting at 0x0
    step(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    seq(1'b1);
    repeat (2) seq(1'b1);

    for (int i = 0; i < 3000; i++) begin
      bit          rst, br, st, rdy;
      logic [1:0]  src;
      logic [31:0] ja, bt;
      rst = ($urandom_range(0, 99) == 0);
      br  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 5) == 0);
      src = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      ja  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      bt  = $urandom() & 32'hFFFF_FFFC;
      step(rst, src, ja, br, bt, st, rdy);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and computes PC+4. Selects the next PC from sequential, ID jump, and EX branch sources.
- Drives a synchronous-ready instruction-memory port.
- Owns the IF/ID pipeline register that feeds decode its instruction word and PC+4, including stall hold and flush-to-bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- NOP_INST, 32'h0000_0000, instruction word injected on bubble/flush (sll $0,$0,0).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- id_pc_src  in  2  jump request from decode; 00 = none, any nonzero = take jump_addr (covers j and jr)
- jump_addr  in  32  jump target from decode (J-format or rs value)
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_branch_target  in  32  branch target from EX
- stall  in  1  hazard-unit stall (load-use); hold PC and IF/ID
- imem_addr  out  32  fetch address (= PC register)
- imem_req  out  1  fetch request
- imem_rdata  in  32  instruction word, valid when imem_ready=1 in the same cycle
- imem_ready  in  1  memory returns imem_rdata this cycle
- if_id_inst_out  out  32  IF/ID instruction
- if_id_pc_plus_4_out  out  32  IF/ID PC+4
- if_id_valid_out  out  1  IF/ID holds a real instruction (0 = bubble)
- perf_fetch_cnt  out  32  instructions accepted into IF/ID (optional feature)
- perf_bubble_cnt  out  32  bubbles inserted into IF/ID (optional feature)

Behaviour:
- Reset, synchronous, while reset=1:
  - PC <= RESET_PC.
  - if_id_inst_out <= NOP_INST, if_id_pc_plus_4_out <= 0, if_id_valid_out <= 0.
  - state <= BOOT, counters <= 0, imem_req = 0.
  - Reset asserted mid-wait abandons the outstanding fetch.
- FSM:
  - BOOT: one cycle, no request, IF/ID loads bubble, go to RUN.
  - RUN: imem_req=1. If imem_ready=0 and no redirect, go to WAIT.
  - WAIT: imem_req=1 with the same address. Go to RUN on imem_ready=1 or on any redirect.
- Fetch: imem_addr = PC. pc_plus_4 = PC + 32'd4, wrapping modulo 2^32.
- Next-PC and IF/ID priority, highest first:
  1. ex_branch_taken:
     - PC <= ex_branch_target; IF/ID <= bubble. Overrides stall and jump.
     - Decode/EX flushing is done elsewhere.
  2. stall:
     - PC and IF/ID hold; the jump request is ignored because its operand may be stale.
     - A fetch completing under stall is discarded and re-fetched.
  3. id_pc_src != 0:
     - PC <= jump_addr; IF/ID <= bubble (the delay-slot fetch is squashed).
  4. imem_ready=1:
     - PC <= pc_plus_4; IF/ID <= {imem_rdata, pc_plus_4, valid=1}.
  5. imem_ready=0:
     - PC holds; IF/ID <= bubble.
- Bubble = {NOP_INST, pc_plus_4 of the current PC, valid=0}.
- Latency: instruction at PC appears on IF/ID outputs the edge after imem_ready=1 (one cycle with a zero-wait memory).
- A redirect while in WAIT changes imem_addr next cycle. The memory must tolerate address change without completing the old request.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each valid IF/ID load.
  - perf_bubble_cnt increments on each bubble load; stall-hold cycles count as neither.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports tied to 32'h0, no counter flops.

Decomposition:
- Shared package pipe_pkg:
  - PC_SRC_* encodings, NOP_INST constant.
  - FSM state typedef (BOOT/RUN/WAIT).
  - Pipeline-register update codes (UPDATE=00, FLUSH=01, HOLD=10), same encoding as the decode-side register control.
- One sub-module, if_pc_sel: combinational next-PC and IF/ID-op selection implementing the priority list.
- The stage instantiates it plus the PC/IF/ID/FSM flops.

Test Plan:
- Reset then zero-wait memory returning 0x20080001, 0x20090002 at 0x0, 0x4:
  - Cycle after BOOT, IF/ID = {0x20080001, 0x4, valid}, then {0x20090002, 0x8, valid}.
  - PC = 0x8.
- imem_ready low 3 cycles at PC=0x10:
  - imem_addr stays 0x10, three bubbles (valid=0, pc_plus_4=0x14).
  - Ready then loads the instruction with pc_plus_4 = 0x14.
- id_pc_src=01, jump_addr=0x100 at PC=0x24: IF/ID bubble, next imem_addr=0x100, then inst at 0x100 with pc_plus_4=0x104.
- stall=1 two cycles with IF/ID = {0x8C080000, 0x30}: outputs unchanged, imem_addr holds; resumes sequentially after release.
- ex_branch_taken=1, target=0x200 simultaneous with stall=1 and id_pc_src=01, jump_addr=0x300: PC <= 0x200, IF/ID bubble.
- PC=0xFFFF_FFFC with ready: pc_plus_4 = 0x0. reset=1 during WAIT: PC = RESET_PC, valid = 0 next edge. With IF_PERF_CNT_EN defined, fetch and bubble counts match the cycle log exactly.
